// File: rtl/ultrasonic_ranger.sv
`timescale 1ns/1ps
// HC-SR04-style ranger: periodic trigger, 2-flop echo synchroniser, echo-width
// timer in clk cycles with timeout, and a result held until the next valid pulse.
module ultrasonic_ranger #(
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1900000,
  parameter int PERIOD_CYCLES  = 3000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        echo,
  output logic        trig,
  output logic [25:0] dist_counter,
  output logic        valid,
  output logic        timeout
);
  localparam logic [25:0] L_TRIG   = 26'(TRIG_CYCLES);
  localparam logic [25:0] L_TO     = 26'(TIMEOUT_CYCLES);
  localparam logic [25:0] L_TO_M1  = 26'(TIMEOUT_CYCLES - 1);
  localparam logic [25:0] L_PER_M1 = 26'(PERIOD_CYCLES - 1);
  localparam logic [25:0] L_ONES   = 26'h3FFFFFF;

  typedef enum logic [1:0] {S_TRIG, S_WAIT_RISE, S_MEASURE, S_HOLD} state_t;

  state_t      r_state, w_state_nxt;
  logic [25:0] r_period, r_cnt, w_cnt_nxt, r_dist, w_dist_nxt;
  logic        r_echo_meta, r_echo_s, r_echo_d;
  logic        r_trig, w_trig_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_timeout, w_timeout_nxt;
  logic        w_rise, w_wrap;

  assign w_rise = r_echo_s & ~r_echo_d;
  assign w_wrap = (r_period == L_PER_M1);

  assign trig         = r_trig;
  assign dist_counter = r_dist;
  assign valid        = r_valid;
  assign timeout      = r_timeout;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_TRIG;
      r_period    <= '0;
      r_cnt       <= '0;
      r_echo_meta <= 1'b0;
      r_echo_s    <= 1'b0;
      r_echo_d    <= 1'b0;
      r_trig      <= 1'b0;
      r_dist      <= '0;
      r_valid     <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_period    <= w_wrap ? '0 : r_period + 26'd1;
      r_cnt       <= w_cnt_nxt;
      r_echo_meta <= echo;
      r_echo_s    <= r_echo_meta;
      r_echo_d    <= r_echo_s;
      r_trig      <= w_trig_nxt;
      r_dist      <= w_dist_nxt;
      r_valid     <= w_valid_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  // r_cnt is shared: trigger length in TRIG, wait time in WAIT_RISE, width in MEASURE.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_trig_nxt    = 1'b0;
    w_valid_nxt   = 1'b0;
    w_dist_nxt    = r_dist;
    w_timeout_nxt = r_timeout;
    unique case (r_state)
      S_TRIG: begin
        if (r_cnt == L_TRIG) begin
          w_state_nxt = S_WAIT_RISE;
          w_cnt_nxt   = '0;
        end else begin
          w_trig_nxt = 1'b1;
          w_cnt_nxt  = r_cnt + 26'd1;
        end
      end
      S_WAIT_RISE: begin
        // a rise on the final wait cycle still starts a measurement
        if (w_rise) begin
          w_state_nxt = S_MEASURE;
          w_cnt_nxt   = 26'd1;
        end else if (r_cnt == L_TO_M1) begin
          w_state_nxt   = S_HOLD;
          w_dist_nxt    = L_ONES;
          w_timeout_nxt = 1'b1;
          w_valid_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 26'd1;
        end
      end
      S_MEASURE: begin
        if (!r_echo_s) begin
          w_state_nxt   = S_HOLD;
          w_dist_nxt    = r_cnt;
          w_timeout_nxt = 1'b0;
          w_valid_nxt   = 1'b1;
        end else if (r_cnt == L_TO) begin
          w_state_nxt   = S_HOLD;
          w_dist_nxt    = L_ONES;
          w_timeout_nxt = 1'b1;
          w_valid_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 26'd1;
        end
      end
      S_HOLD: begin
        if (w_wrap) begin
          w_state_nxt = S_TRIG;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_TRIG;
        w_cnt_nxt   = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_ultrasonic_ranger.sv
`timescale 1ns/1ps
// Directed bench for ultrasonic_ranger: one table row per measurement period,
// plus reset and mid-measurement reset sequences. k counts negedges from trig fall.
module tb_ultrasonic_ranger;
  localparam int TRIG   = 10;
  localparam int TO     = 1000;
  localparam int PERIOD = 2100;
  localparam logic [25:0] ONES = 26'h3FFFFFF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        echo;
  logic        trig;
  logic [25:0] dist_counter;
  logic        valid;
  logic        timeout;

  int n_chk  = 0;
  int n_fail = 0;
  logic [25:0] m_dist = '0;
  logic        m_to   = 1'b0;

  ultrasonic_ranger #(.TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TO), .PERIOD_CYCLES(PERIOD)) dut (
    .clk(clk), .reset_n(reset_n), .echo(echo), .trig(trig),
    .dist_counter(dist_counter), .valid(valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // d: negedge at which echo rises; w: raw width in cycles (0 = no echo);
  // exp_vk: negedge index at which valid is expected to be seen
  typedef struct {
    int          d;
    int          w;
    bit          stuck;
    bit          tog;
    logic [25:0] exp_dist;
    bit          exp_to;
    int          exp_vk;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input bit nxt_stuck, input int idx);
    int hi, k, nvalid, vk;
    logic hold_ok;
    logic [25:0] hd, vd;
    logic ht, vt;
    hi = 0;
    while (trig === 1'b1 && hi < 50) begin
      hi++;
      @(negedge clk);
    end
    chk($sformatf("v%0d.trig_width", idx), hi, TRIG);
    hold_ok = 1'b1; nvalid = 0; vk = -1; vd = '0; vt = 1'b0;
    hd = m_dist; ht = m_to;
    k = 0;
    while (!(k > 0 && trig === 1'b1) && k < 2300) begin
      if (valid === 1'b1) begin
        nvalid++; vk = k; vd = dist_counter; vt = timeout;
        hd = v.exp_dist; ht = v.exp_to;
      end
      if (dist_counter !== hd || timeout !== ht) hold_ok = 1'b0;
      echo = v.stuck || (k >= v.d && k < v.d + v.w) ||
             (v.tog && k >= 1500 && k < 1600 && k[1]);
      @(negedge clk);
      k++;
    end
    echo = nxt_stuck;
    chk($sformatf("v%0d.period", idx), k, PERIOD - TRIG);
    chk($sformatf("v%0d.valid_count", idx), nvalid, 1);
    chk($sformatf("v%0d.valid_time", idx), vk, v.exp_vk);
    chk($sformatf("v%0d.dist", idx), 32'(vd), 32'(v.exp_dist));
    chk($sformatf("v%0d.timeout", idx), 32'(vt), 32'(v.exp_to));
    chk($sformatf("v%0d.hold", idx), 32'(hold_ok), 32'd1);
    m_dist = v.exp_dist;
    m_to   = v.exp_to;
  endtask

  initial begin
    int hi, nv;
    vecs[0]  = '{49,   290,  0, 0, 26'd290,  1'b0, 342};   // normal echo
    vecs[1]  = '{0,    0,    0, 0, ONES,     1'b1, 1000};  // no echo
    vecs[2]  = '{20,   100,  0, 0, 26'd100,  1'b0, 123};   // recovery after timeout
    vecs[3]  = '{0,    0,    1, 0, ONES,     1'b1, 1000};  // stuck high
    vecs[4]  = '{0,    0,    1, 0, ONES,     1'b1, 1000};  // stuck high again
    vecs[5]  = '{10,   1200, 0, 0, ONES,     1'b1, 1013};  // too long: width hits TO
    vecs[6]  = '{5,    1,    0, 0, 26'd1,    1'b0, 9};     // 1-cycle pulse
    vecs[7]  = '{5,    1000, 0, 0, 26'd1000, 1'b0, 1008};  // fall wins at TO
    vecs[8]  = '{5,    1001, 0, 0, ONES,     1'b1, 1008};  // one past TO
    vecs[9]  = '{997,  10,   0, 0, 26'd10,   1'b0, 1010};  // rise on last wait cycle
    vecs[10] = '{10,   50,   0, 1, 26'd50,   1'b0, 63};    // toggling in HOLD

    reset_n = 1'b0;
    echo    = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst.trig",    32'(trig), 32'd0);
    chk("rst.dist",    32'(dist_counter), 32'd0);
    chk("rst.valid",   32'(valid), 32'd0);
    chk("rst.timeout", 32'(timeout), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst.first_trig", 32'(trig), 32'd1);

    for (int i = 0; i < 11; i++)
      run_vec(vecs[i], (i < 10) ? vecs[i+1].stuck : 1'b0, i);

    // reset in the middle of a 500-cycle echo
    hi = 0;
    while (trig === 1'b1 && hi < 50) begin
      hi++;
      @(negedge clk);
    end
    chk("mid.trig_width", hi, TRIG);
    nv = 0;
    for (int k = 0; k < 260; k++) begin
      if (valid === 1'b1) nv++;
      echo = (k >= 10 && k < 510);
      @(negedge clk);
    end
    chk("mid.no_valid_before", nv, 0);
    reset_n = 1'b0;
    echo    = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid.rst_dist",    32'(dist_counter), 32'd0);
    chk("mid.rst_valid",   32'(valid), 32'd0);
    chk("mid.rst_timeout", 32'(timeout), 32'd0);
    chk("mid.rst_trig",    32'(trig), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid.retrigger", 32'(trig), 32'd1);
    nv = 0;
    for (int k = 0; k < 30; k++) begin
      if (valid === 1'b1) nv++;
      @(negedge clk);
    end
    chk("mid.no_valid_after", nv, 0);
    chk("mid.dist_after", 32'(dist_counter), 32'd0);
    chk("mid.trig_low_after", 32'(trig), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_chk);
    $fatal(1, "watchdog");
  end
endmodule
